// File: rtl/stub_input_pkg.sv
// Shared constants for the stub link buffer: link word layout, mode encodings
// and drop counter width.
package stub_input_pkg;
   localparam int LINK_W     = 32;
   localparam int TAG_HI     = 31;
   localparam int TAG_LO     = 28;
   localparam int TAG_W      = TAG_HI - TAG_LO + 1;
   localparam int DROP_CNT_W = 16;

   typedef enum logic {
      MODE_STREAM   = 1'b0,
      MODE_PLAYBACK = 1'b1
   } mode_e;

   function automatic logic [TAG_W-1:0] link_tag(input logic [LINK_W-1:0] word);
      return word[TAG_HI:TAG_LO];
   endfunction
endpackage

// File: rtl/stub_sdp_ram.sv
// Simple dual-port stub storage: one write port, one registered read port,
// read-before-write when both ports hit the same address.
module stub_sdp_ram
   import stub_input_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 36,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
   end

   // The read register only moves on a read so the output holds between reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/stub_link_buffer.sv
// Stitches NLINK tagged link words into stubs, buffered as a FIFO (stream) or
// replayed from address 0 (playback). Define STUB_LINK_BUFFER_DEDUP_EN to drop repeats.
module stub_link_buffer
   import stub_input_pkg::*;
#(
   parameter int NLINK    = 2,
   parameter int LANE_W   = 18,
   parameter int DEPTH    = 1024,
   parameter int PLAY_LEN = 100
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NLINK*LINK_W-1:0] link_data,
   input  logic [NLINK-1:0]        link_valid,
   input  logic                    mode,
   input  logic                    read_en,
   input  logic                    BC0,
   output logic [NLINK*LANE_W-1:0] data_out,
   output logic                    data_valid,
   output logic                    empty,
   output logic                    full,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = NLINK * LANE_W;
   localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
   localparam logic [AW:0] PLAY_LEN_C = (AW+1)'(PLAY_LEN);

   logic [SW-1:0]         cand;
   logic                  tags_eq, cand_ok, wr_req;
   logic [SW-1:0]         cap_q;
   logic                  cap_vld_q;
   mode_e                 mode_in, mode_q;
   logic                  stream_m, pop, push, drop, pb_rd;
   logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]           count_q, count_d;
   logic [AW-1:0]         pb_addr_q, pb_addr_d, rd_addr;
   logic [AW:0]           pb_left_q, pb_left_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic                  data_valid_q;
   logic                  link_unused;

   // Bits between the payload and the tag are not carried into the stub.
   assign link_unused = ^link_data;

   always_comb begin
      cand    = '0;
      tags_eq = 1'b1;
      for (int k = 0; k < NLINK; k++) begin
         cand[(NLINK-1-k)*LANE_W +: LANE_W] = link_data[k*LINK_W +: LANE_W];
         if (link_tag(link_data[k*LINK_W +: LINK_W]) != link_tag(link_data[LINK_W-1:0]))
            tags_eq = 1'b0;
      end
   end

   assign cand_ok = (&link_valid) && tags_eq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_q     <= '0;
         cap_vld_q <= 1'b0;
      end else begin
         cap_vld_q <= cand_ok;
         if (cand_ok) cap_q <= cand;
      end
   end

`ifdef STUB_LINK_BUFFER_DEDUP_EN
   logic dup_q;

   // cap_q still holds the previous candidate when the new one is compared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        dup_q <= 1'b0;
      else if (cand_ok) dup_q <= (cand == cap_q);
   end

   assign wr_req = cap_vld_q && (cap_q != '0) && !dup_q;
`else
   assign wr_req = cap_vld_q && (cap_q != '0);
`endif

   assign mode_in  = mode_e'(mode);
   assign stream_m = (mode_q == MODE_STREAM);
   assign pop      = stream_m && read_en && (count_q != '0);
   assign push     = stream_m && wr_req && ((count_q != DEPTH_C) || pop);
   assign drop     = stream_m && wr_req && (count_q == DEPTH_C) && !pop;
   assign pb_rd    = !stream_m && read_en && (BC0 || (pb_left_q != '0));

   always_comb begin
      wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
      pb_addr_d  = pb_addr_q;
      pb_left_d  = pb_left_q;
      rd_addr    = stream_m ? rptr_q : pb_addr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (!stream_m) begin
         if (BC0) begin
            rd_addr   = '0;
            pb_addr_d = '0;
            pb_left_d = PLAY_LEN_C;
         end
         // The address stops on the last replayed entry rather than running past it.
         if (pb_rd) begin
            pb_left_d = pb_left_d - 1'b1;
            pb_addr_d = (pb_left_d != '0) ? rd_addr + 1'b1 : rd_addr;
         end
      end

      if (mode_in != mode_q) begin
         if (mode_in == MODE_PLAYBACK) begin
            pb_addr_d = '0;
            pb_left_d = PLAY_LEN_C;
         end else begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q       <= MODE_STREAM;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         pb_addr_q    <= '0;
         pb_left_q    <= PLAY_LEN_C;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         mode_q       <= mode_in;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         pb_addr_q    <= pb_addr_d;
         pb_left_q    <= pb_left_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
         data_valid_q <= pop | pb_rd;
      end
   end

   stub_sdp_ram #(
      .DEPTH (DEPTH),
      .WIDTH (SW)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (push),
      .wr_addr_i (wptr_q),
      .wr_data_i (cap_q),
      .rd_en_i   (pop | pb_rd),
      .rd_addr_i (rd_addr),
      .rd_data_o (data_out)
   );

   assign data_valid = data_valid_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == DEPTH_C);
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
endmodule
